// File: rtl/demux_4way_buffered.sv
// demux_4way_buffered: registered 1-to-4 valid/ready demultiplexer, one-entry buffer per channel.
// Optional macro DEMUX_BYPASS_EN adds a zero-latency path into an empty, ready channel.
`default_nettype none

module demux_4way_buffered #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] In,
  input  logic [1:0]   Choose,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] Out1,
  output logic [N-1:0] Out2,
  output logic [N-1:0] Out3,
  output logic [N-1:0] Out4,
  output logic [3:0]   out_valid,
  input  logic [3:0]   out_ready
);

  logic [N-1:0] buf_data [4];
  logic [N-1:0] out_data [4];
  logic [3:0]   buf_valid;
  logic [3:0]   sel;
  logic [3:0]   drain;
  logic [3:0]   load_en;
  logic         bypass;

  assign sel      = 4'b0001 << Choose;
  assign in_ready = ~buf_valid[Choose] | out_ready[Choose];
  assign drain    = buf_valid & out_ready;
  assign load_en  = sel & {4{in_valid & in_ready & ~bypass}};

`ifdef DEMUX_BYPASS_EN
  logic [3:0] byp_en;

  // Bypass only into an empty buffer, so per-channel ordering is preserved.
  assign bypass    = in_valid & ~buf_valid[Choose] & out_ready[Choose];
  assign byp_en    = sel & {4{bypass}};
  assign out_valid = buf_valid | byp_en;
`else
  assign bypass    = 1'b0;
  assign out_valid = buf_valid;
`endif

  generate
    for (genvar k = 0; k < 4; k++) begin : g_ch
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          buf_data[k]  <= '0;
          buf_valid[k] <= 1'b0;
        end else if (load_en[k]) begin
          buf_data[k]  <= In;
          buf_valid[k] <= 1'b1;
        end else if (drain[k]) begin
          buf_valid[k] <= 1'b0;
        end
      end

`ifdef DEMUX_BYPASS_EN
      assign out_data[k] = byp_en[k] ? In : buf_data[k];
`else
      assign out_data[k] = buf_data[k];
`endif
    end
  endgenerate

  assign Out1 = out_data[0];
  assign Out2 = out_data[1];
  assign Out3 = out_data[2];
  assign Out4 = out_data[3];

endmodule

`default_nettype wire

// File: tb/tb_demux_4way_buffered.sv
// tb_demux_4way_buffered: directed and scoreboard checks for demux_4way_buffered.
`default_nettype none

module tb_demux_4way_buffered;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] In = '0;
  logic [1:0]  Choose = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] Out1, Out2, Out3, Out4;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = '0;

  int pass_cnt = 0;
  int total_cnt = 0;

  demux_4way_buffered #(.N(32)) dut (
    .clk(clk), .rst(rst), .In(In), .Choose(Choose), .in_valid(in_valid),
    .in_ready(in_ready), .Out1(Out1), .Out2(Out2), .Out3(Out3), .Out4(Out4),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] get_out(input int k);
    case (k)
      0:       return Out1;
      1:       return Out2;
      2:       return Out3;
      default: return Out4;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total_cnt++;
    if (out_valid !== 4'b0000) $display("FAIL reset_out_valid got %b want 0000", out_valid);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    tick();
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
    else pass_cnt++;
    // Fill ch2 with a stalled consumer, then hit reset mid-cycle.
    Choose = 2'b01; In = 32'hDEADBEEF; in_valid = 1'b1; out_ready = 4'b0000;
    tick();
    in_valid = 1'b0;
    #1;
    total_cnt++;
    if (Out2 !== 32'hDEADBEEF || out_valid !== 4'b0010)
      $display("FAIL reset_preload got Out2=%h v=%b want deadbeef 0010", Out2, out_valid);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (out_valid !== 4'b0000 || Out2 !== 32'h0)
      $display("FAIL reset_async got Out2=%h v=%b want 0 0000", Out2, out_valid);
    else pass_cnt++;
    tick();
    #2 rst = 1'b0;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_ready got %b want 1", in_ready);
    else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if (out_valid !== 4'b0000) $display("FAIL reset_no_glitch got %b want 0000", out_valid);
    else pass_cnt++;
  endtask

`ifndef DEMUX_BYPASS_EN
  task automatic test_steering();
    logic [31:0] words [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    out_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      Choose = 2'(i); In = words[i]; in_valid = 1'b1;
      tick();
      total_cnt++;
      if (out_valid !== (4'b0001 << i) || get_out(i) !== words[i])
        $display("FAIL steer_ch%0d got v=%b d=%h want v=%b d=%h", i + 1, out_valid,
                 get_out(i), 4'b0001 << i, words[i]);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    tick();
    total_cnt++;
    if (out_valid !== 4'b0000) $display("FAIL steer_drained got %b want 0000", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    out_ready = 4'b0000;
    Choose = 2'b10; In = 32'hA; in_valid = 1'b1;
    tick();
    total_cnt++;
    if (out_valid !== 4'b0100 || Out3 !== 32'hA)
      $display("FAIL bp_first got v=%b Out3=%h want 0100 a", out_valid, Out3);
    else pass_cnt++;
    In = 32'hB;
    #1;
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL bp_stall_ready got %b want 0", in_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (Out3 !== 32'hA || out_valid !== 4'b0100)
      $display("FAIL bp_hold got Out3=%h v=%b want a 0100", Out3, out_valid);
    else pass_cnt++;
    out_ready = 4'b0100;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", in_ready);
    else pass_cnt++;
    tick();
    in_valid = 1'b0;
    total_cnt++;
    if (Out3 !== 32'hB || out_valid !== 4'b0100)
      $display("FAIL bp_reload got Out3=%h v=%b want b 0100", Out3, out_valid);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (out_valid !== 4'b0000) $display("FAIL bp_drain got %b want 0000", out_valid);
    else pass_cnt++;
    out_ready = 4'b0000;
  endtask

  task automatic test_independence();
    out_ready = 4'b0000;
    Choose = 2'b00; In = 32'h99; in_valid = 1'b1;
    tick();
    #1;
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL indep_ch1_full got %b want 0", in_ready);
    else pass_cnt++;
    Choose = 2'b11; In = 32'h55;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL indep_switch_ready got %b want 1", in_ready);
    else pass_cnt++;
    tick();
    in_valid = 1'b0;
    total_cnt++;
    if (Out4 !== 32'h55 || Out1 !== 32'h99 || out_valid !== 4'b1001)
      $display("FAIL indep_ch4 got Out4=%h Out1=%h v=%b want 55 99 1001", Out4, Out1, out_valid);
    else pass_cnt++;
    out_ready = 4'b1111;
    tick();
    out_ready = 4'b0000;
    total_cnt++;
    if (out_valid !== 4'b0000) $display("FAIL indep_drain got %b want 0000", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_streaming();
    logic [31:0] q [4][$];
    logic [3:0]  mvalid = 4'b0000;
    logic        exp_ready;
    int          sent = 0;
    int          cycles = 0;
    int          c;
    while ((sent < 100 || mvalid != 4'b0000) && cycles < 3000) begin
      cycles++;
      if (sent < 100) begin
        in_valid  = 1'($urandom_range(0, 1));
        Choose    = 2'($urandom_range(0, 3));
        In        = $urandom;
        out_ready = 4'($urandom_range(0, 15));
      end else begin
        in_valid  = 1'b0;
        out_ready = 4'b1111;
      end
      #1;
      c = int'(Choose);
      exp_ready = ~mvalid[c] | out_ready[c];
      total_cnt++;
      if (in_ready !== exp_ready || out_valid !== mvalid)
        $display("FAIL stream_hs cyc %0d got rdy=%b v=%b want rdy=%b v=%b", cycles, in_ready,
                 out_valid, exp_ready, mvalid);
      else pass_cnt++;
      for (int k = 0; k < 4; k++) begin
        if (mvalid[k] && out_ready[k]) begin
          total_cnt++;
          if (get_out(k) !== q[k][0])
            $display("FAIL stream_data ch%0d got %h want %h", k + 1, get_out(k), q[k][0]);
          else pass_cnt++;
          void'(q[k].pop_front());
          mvalid[k] = 1'b0;
        end
      end
      if (in_valid && exp_ready) begin
        q[c].push_back(In);
        mvalid[c] = 1'b1;
        sent++;
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 4'b0000;
    total_cnt++;
    if (sent != 100 || mvalid != 4'b0000)
      $display("FAIL stream_timeout got sent=%0d pending=%b want 100 0000", sent, mvalid);
    else pass_cnt++;
  endtask
`else
  task automatic test_bypass();
    out_ready = 4'b0010;
    Choose = 2'b01; In = 32'h7; in_valid = 1'b1;
    #1;
    total_cnt++;
    if (out_valid !== 4'b0010 || Out2 !== 32'h7 || in_ready !== 1'b1)
      $display("FAIL bypass_comb got v=%b Out2=%h rdy=%b want 0010 7 1", out_valid, Out2, in_ready);
    else pass_cnt++;
    tick();
    in_valid = 1'b0;
    out_ready = 4'b0000;
    #1;
    total_cnt++;
    if (out_valid !== 4'b0000) $display("FAIL bypass_empty got %b want 0000", out_valid);
    else pass_cnt++;
    Choose = 2'b01; In = 32'h8; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total_cnt++;
    if (out_valid !== 4'b0010 || Out2 !== 32'h8)
      $display("FAIL bypass_buffered got v=%b Out2=%h want 0010 8", out_valid, Out2);
    else pass_cnt++;
    out_ready = 4'b1111;
    tick();
    out_ready = 4'b0000;
    total_cnt++;
    if (out_valid !== 4'b0000) $display("FAIL bypass_drain got %b want 0000", out_valid);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
`ifndef DEMUX_BYPASS_EN
    test_steering();
    test_backpressure();
    test_independence();
    test_streaming();
`else
    test_bypass();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/demux_4way_buffered.md
# demux_4way_buffered

Registered 1-to-4 demultiplexer with valid/ready handshaking, the steering counterpart of the datapath's 4:1 select multiplexer. It accepts one n-bit word per cycle tagged with a 2-bit destination select and delivers it to one of four independent output channels. Each channel has a one-entry buffer, so a stalled consumer blocks only its own channel. The block sits between pipeline stages wherever one producer feeds four consumers, such as result routing to writeback, CSR, branch and store paths.

## Interface
- n, 32, data width in bits of the input and every output channel
- clk  input  1  clock, all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-high
- In  input  n  input data word
- Choose  input  2  destination select: 00 → ch1, 01 → ch2, 10 → ch3, 11 → ch4
- in_valid  input  1  producer has a word on In/Choose
- in_ready  output  1  block accepts the word this cycle
- Out1..Out4  output  n each  channel data
- out_valid  output  4  bit k-1 = channel k holds valid data
- out_ready  input  4  bit k-1 = consumer k takes data this cycle

## Operation
- Per channel k: buffer register buf_data[k] (n bits) and flag buf_valid[k].
- Outk = buf_data[k], out_valid[k-1] = buf_valid[k]; this is overridden in bypass mode only (see Configuration).
- in_ready = ~buf_valid[Choose] | out_ready[Choose].
  - Purely combinational from Choose, out_ready and the buffer state.
  - Never depends on in_valid.
- Accept = in_valid & in_ready. On accept, the selected channel loads In and sets its valid flag.
- Drain of channel k = out_valid[k-1] & out_ready[k-1]. It clears buf_valid[k] unless channel k is loaded in the same cycle; load wins.
- Channels drain independently. Up to four drains and one load can occur in the same cycle.
- Non-selected channels are unaffected by In and Choose.
- Ordering: words to the same channel are delivered in acceptance order. There is no ordering guarantee across channels.
- Producer rule: In and Choose must be held stable while in_valid=1 and in_ready=0. The block does not check this.
- Consumer rule: out_ready may toggle freely. Outk holds while out_valid is high and the channel is not drained.

## Timing
- Reset (asynchronous, immediate): all buf_valid=0 and all buf_data=0. So out_valid=4'b0000, Out1..Out4=0, and in_ready=1.
- Latency, default build: a word accepted at edge t is visible on Outk after edge t.
- Throughput: 1 word per cycle into any channel whose consumer holds out_ready=1.
- Full channel with out_ready=0: in_ready=0 for that Choose only. Switching Choose to an empty channel gives in_ready=1 in the same cycle.
- Full channel with out_ready=1: load and drain occur in the same edge, with no bubble.
- Reset asserted mid-transfer:
  - Buffered words are discarded.
  - The handshake in progress is not completed.
  - No output pulses glitch high after reset release.

## Configuration
- DEMUX_BYPASS_EN defined: zero-latency bypass.
  - Condition: in_valid=1, buf_valid[Choose]=0 and out_ready[Choose]=1.
  - Effect: the selected Outk=In and out_valid[k-1]=1 combinationally, the transfer completes in the same cycle, and the buffer is not loaded.
  - All other cases behave as in the default build.
  - Ordering is preserved, because bypass occurs only when the buffer is empty.
- DEMUX_BYPASS_EN undefined: no combinational path from In/in_valid to any output. Latency is exactly 1 cycle.

## Test plan
- Reset:
  - Stimulus: assert rst mid-cycle with ch2 full (0xDEADBEEF).
  - Response: out_valid=0000 and Out2=0 immediately; in_ready=1 after release.
- Steering:
  - Stimulus: Choose=00,01,10,11 with In=0x11,0x22,0x33,0x44 on consecutive cycles, out_ready=1111.
  - Response: each word appears once, one cycle later, on Out1..Out4 respectively.
- Backpressure:
  - Stimulus: out_ready=0000, send 0xA to ch3, then 0xB to ch3.
  - Response: in_ready=0 on the second word; Out3 holds 0xA.
  - Follow-up: raise out_ready[2]. Response: 0xA drains, 0xB loads on the same edge, Out3=0xB next cycle.
- Channel independence:
  - Stimulus: ch1 full and stalled; send 0x55 to ch4.
  - Response: accepted immediately; Out4=0x55 next cycle; Out1 is unchanged.
- Streaming:
  - Stimulus: 100 random words to random channels, with random out_ready at 50% duty.
  - Response: per-channel scoreboard matches in order, with no loss or duplication.
- Bypass build:
  - Stimulus: DEMUX_BYPASS_EN defined, ch2 empty, out_ready[1]=1, Choose=01, In=0x7.
  - Response: out_valid[1]=1 and Out2=0x7 in the same cycle; buffer stays empty.
